// File: rtl/flappy_pkg.sv
// flappy_pkg: state encoding and default physics constants shared by the game core and display.
package flappy_pkg;
  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_FLY  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;
  typedef enum logic [1:0] {S_WAIT = ST_WAIT, S_FLY = ST_FLY, S_DEAD = ST_DEAD} state_e;
  localparam int DEF_Y_W         = 10;
  localparam int DEF_V_W         = 6;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_BIRD_H      = 24;
  localparam int DEF_START_Y     = 228;
  localparam int DEF_GRAVITY     = 1;
  localparam int DEF_FLAP_VEL    = -8;
  localparam int DEF_VMAX        = 10;
  localparam int DEF_DIGITS      = 4;
  localparam int DEF_DEAD_FRAMES = 60;
endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: multi-digit BCD up-counter that saturates at all nines instead of wrapping.
module bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   value
);
  logic [4*DIGITS-1:0] value_q, value_d;
  logic                c;
  always_comb begin
    value_d = value_q;
    c = inc && (value_q != {DIGITS{4'h9}});
    for (int i = 0; i < DIGITS; i++) begin
      value_d[4*i+:4] = c ? ((value_q[4*i+:4] == 4'd9) ? 4'd0 : value_q[4*i+:4] + 4'd1) : value_q[4*i+:4];
      c = c && (value_q[4*i+:4] == 4'd9);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clr) value_q <= '0;
    else value_q <= value_d;
  end
  assign value = value_q;
endmodule

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: game FSM, per-frame bird physics, BCD score and best score.
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int Y_W         = DEF_Y_W,
  parameter int V_W         = DEF_V_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int BIRD_H      = DEF_BIRD_H,
  parameter int START_Y     = DEF_START_Y,
  parameter int GRAVITY     = DEF_GRAVITY,
  parameter int FLAP_VEL    = DEF_FLAP_VEL,
  parameter int VMAX        = DEF_VMAX,
  parameter int DIGITS      = DEF_DIGITS,
  parameter int DEAD_FRAMES = DEF_DEAD_FRAMES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  flap,
  input  logic                  hit,
  input  logic                  pipe_passed,
  output logic [1:0]            state,
  output logic [Y_W-1:0]        bird_y,
  output logic signed [V_W-1:0] bird_vel,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   best,
  output logic                  died
);
  localparam int CW = $clog2(DEAD_FRAMES + 1);
  localparam logic signed [V_W-1:0] FLAP_V = V_W'(FLAP_VEL);
  state_e                state_q, state_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic signed [V_W-1:0] vel_q, vel_d, vg_sat;
  logic [4*DIGITS-1:0]   best_q, best_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  died_q, died_d, pend_q, pend_d;
  logic                  fe, floor_hit, ceil_hit, to_dead;
  logic signed [Y_W:0]   y_n;
  logic signed [V_W:0]   v_g;
  // A flap arriving in the tick cycle itself is folded into that tick.
  assign fe        = pend_q || flap;
  assign y_n       = $signed({1'b0, y_q}) + (Y_W+1)'(vel_q);
  assign v_g       = (V_W+1)'(vel_q) + (V_W+1)'(GRAVITY);
  assign vg_sat    = (v_g > (V_W+1)'(VMAX)) ? V_W'(VMAX) : v_g[V_W-1:0];
  assign floor_hit = int'(y_n) + BIRD_H >= SCREEN_H;
  assign ceil_hit  = y_n[Y_W];
  assign to_dead   = frame_tick && (state_q == S_FLY) && (floor_hit || hit);
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    died_d  = 1'b0;
    pend_d  = frame_tick ? 1'b0 : fe;
    if (frame_tick) begin
      case (state_q)
        S_WAIT: begin
          if (fe) begin
            state_d = S_FLY;
            vel_d   = FLAP_V;
          end
        end
        S_FLY: begin
          if (floor_hit) y_d = Y_W'(SCREEN_H - BIRD_H);
          else if (!hit) begin
            y_d   = ceil_hit ? '0 : y_n[Y_W-1:0];
            vel_d = fe ? FLAP_V : (ceil_hit ? '0 : vg_sat);
          end
          if (floor_hit || hit) begin
            state_d = S_DEAD;
            died_d  = 1'b1;
            cnt_d   = '0;
            best_d  = (score > best_q) ? score : best_q;
          end
        end
        S_DEAD: begin
          if (fe && cnt_q == CW'(DEAD_FRAMES)) begin
            state_d = S_WAIT;
            y_d     = Y_W'(START_Y);
            vel_d   = '0;
          end else if (cnt_q != CW'(DEAD_FRAMES)) cnt_d = cnt_q + 1'b1;
        end
        default: state_d = S_WAIT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
      y_q     <= Y_W'(START_Y);
      vel_q   <= '0;
      best_q  <= '0;
      cnt_q   <= '0;
      died_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      best_q  <= best_d;
      cnt_q   <= cnt_d;
      died_q  <= died_d;
      pend_q  <= pend_d;
    end
  end
  // The increment is dropped on the death tick so best sees the pre-increment score.
  bcd_counter #(.DIGITS(DIGITS)) u_score (
    .clk  (clk),
    .rst  (rst),
    .clr  (frame_tick && state_q == S_WAIT && fe),
    .inc  (pipe_passed && state_q == S_FLY && !to_dead),
    .value(score)
  );
  assign state    = state_q;
  assign bird_y   = y_q;
  assign bird_vel = vel_q;
  assign best     = best_q;
  assign died     = died_q;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed and random stimulus checked against a behavioural game model.
module tb_flappy_game_ctrl;
  logic              clk = 1'b0;
  logic              rst, frame_tick, flap, hit, pipe_passed;
  logic [1:0]        state;
  logic [9:0]        bird_y;
  logic signed [5:0] bird_vel;
  logic [15:0]       score, best;
  logic              died;
  int n_tests = 0, n_fail = 0;
  int m_st, m_y, m_v, m_sc, m_best, m_cnt;
  bit m_pend, m_died;
  always #5 clk = ~clk;
  flappy_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .flap(flap), .hit(hit),
    .pipe_passed(pipe_passed), .state(state), .bird_y(bird_y), .bird_vel(bird_vel),
    .score(score), .best(best), .died(died)
  );
  function automatic int to_bcd(int n);
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      r += (n % 10) << (4 * i);
      n /= 10;
    end
    return r;
  endfunction
  task automatic chk(string tag, int obs, int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask
  task automatic model(bit r, bit t, bit f, bit h, bit p);
    bit fe, dying;
    int old_st, yn;
    if (r) begin
      m_st = 0; m_y = 228; m_v = 0; m_sc = 0; m_best = 0; m_cnt = 0; m_pend = 0; m_died = 0;
      return;
    end
    fe = m_pend || f;
    dying = 0;
    old_st = m_st;
    m_died = 0;
    m_pend = t ? 0 : fe;
    if (t) begin
      if (old_st == 0 && fe) begin
        m_st = 1; m_v = -8; m_sc = 0;
      end else if (old_st == 1) begin
        yn = m_y + m_v;
        if (yn + 24 >= 480) begin
          m_y = 456; dying = 1;
        end else if (h) dying = 1;
        else if (yn < 0) begin
          m_y = 0; m_v = fe ? -8 : 0;
        end else begin
          m_y = yn; m_v = fe ? -8 : (m_v + 1 > 10 ? 10 : m_v + 1);
        end
        if (dying) begin
          m_st = 2; m_died = 1; m_cnt = 0;
          if (m_sc > m_best) m_best = m_sc;
        end
      end else if (old_st == 2) begin
        if (fe && m_cnt == 60) begin
          m_st = 0; m_y = 228; m_v = 0;
        end else if (m_cnt < 60) m_cnt++;
      end
    end
    if (p && old_st == 1 && !dying && m_sc < 9999) m_sc++;
  endtask
  task automatic step(bit r, bit t, bit f, bit h, bit p);
    rst = r; frame_tick = t; flap = f; hit = h; pipe_passed = p;
    @(posedge clk);
    model(r, t, f, h, p);
    @(negedge clk);
    chk("state", int'(state), m_st);
    chk("bird_y", int'(bird_y), m_y);
    chk("bird_vel", int'(bird_vel), m_v);
    chk("score", int'(score), to_bcd(m_sc));
    chk("best", int'(best), to_bcd(m_best));
    chk("died", int'(died), int'(m_died));
  endtask
  task automatic restart();
    for (int i = 0; i < 60; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("restart_state", int'(state), 0);
    step(0, 1, 1, 0, 0);
  endtask
  initial begin
    int k;
    step(1, 0, 0, 0, 0);
    chk("rst_state", int'(state), 0);
    chk("rst_y", int'(bird_y), 228);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("wait_y", int'(bird_y), 228);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("fly_state", int'(state), 1);
    chk("fly_vel0", int'(bird_vel), -8);
    step(0, 1, 0, 0, 0);
    chk("fly_y1", int'(bird_y), 220);
    chk("fly_vel1", int'(bird_vel), -7);
    step(0, 1, 0, 0, 0);
    chk("fly_y2", int'(bird_y), 213);
    chk("fly_vel2", int'(bird_vel), -6);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0);
    chk("hit_state", int'(state), 2);
    chk("hit_score", int'(score), 16'h0012);
    chk("hit_best", int'(best), 16'h0012);
    chk("hit_died", int'(died), 1);
    for (int i = 0; i < 60; i++) step(0, 1, 1, 0, 0);
    chk("early_flap", int'(state), 2);
    step(0, 1, 1, 0, 0);
    chk("late_flap", int'(state), 0);
    chk("late_y", int'(bird_y), 228);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    chk("r2_score", int'(score), 16'h0005);
    chk("r2_best", int'(best), 16'h0012);
    restart();
    k = 0;
    while (state == 2'd1 && k < 200) begin
      step(0, 1, 0, 0, 0);
      k++;
    end
    chk("floor_state", int'(state), 2);
    chk("floor_y", int'(bird_y), 456);
    restart();
    for (int i = 0; i < 10001; i++) step(0, 0, 0, 0, 1);
    chk("sat_score", int'(score), 16'h9999);
    k = 0;
    while (bird_y >= 10'd8 && k < 100) begin
      step(0, 1, 1, 0, 0);
      k++;
    end
    step(0, 1, 1, 0, 0);
    chk("ceil_flap_y", int'(bird_y), 0);
    chk("ceil_flap_v", int'(bird_vel), -8);
    step(0, 1, 0, 0, 0);
    chk("ceil_y", int'(bird_y), 0);
    chk("ceil_v", int'(bird_vel), 0);
    step(1, 1, 1, 1, 1);
    chk("rst_mid_state", int'(state), 0);
    chk("rst_mid_best", int'(best), 0);
    for (int i = 0; i < 5000; i++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
